// File: rtl/my_alu.sv
// my_alu: 16-bit PDP-11 ALU; one-hot op strobes, registered result/mask/flags.
// Byte-mode datapath is built only when MYALU_BYTE_OPS_EN is defined.
module my_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   input  logic        ni,
   input  logic        ci,
   input  logic        mbyte,
   input  logic        add,
   input  logic        adc,
   input  logic        sub,
   input  logic        sbc,
   input  logic        inc2,
   input  logic        dec2,
   input  logic        inc,
   input  logic        dec,
   input  logic        clr,
   input  logic        com,
   input  logic        neg,
   input  logic        tst,
   input  logic        ror,
   input  logic        rol,
   input  logic        asr,
   input  logic        asl,
   input  logic        sxt,
   input  logic        mov,
   input  logic        cmp,
   input  logic        bit_,
   input  logic        bic,
   input  logic        bis,
   input  logic        exor,
   input  logic        swab,
   output logic [15:0] final_result,
   output logic [3:0]  ccmask,
   output logic [3:0]  final_flags
);

   typedef enum logic [4:0] {
      OP_NONE, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_INC2, OP_DEC2, OP_INC, OP_DEC, OP_CLR,
      OP_COM, OP_NEG, OP_TST, OP_ROR, OP_ROL,
      OP_ASR, OP_ASL, OP_SXT, OP_MOV, OP_CMP,
      OP_BIT, OP_BIC, OP_BIS, OP_EXOR, OP_SWAB
   } op_e;

   op_e         w_op;
   logic        w_byte;
   logic [15:0] w_wmask;
   logic [15:0] w_minneg;
   logic [15:0] w_maxpos;
   logic [15:0] w_a;
   logic [15:0] w_b;
   logic        w_sa;
   logic        w_sb;
   logic [16:0] w_sum;
   logic [16:0] w_dif;
   logic [16:0] w_cmpd;
   logic        w_sum_s;
   logic        w_dif_s;
   logic        w_cmp_s;
   logic [15:0] w_r;
   logic        w_c;
   logic        w_v;
   logic        w_vnc;
   logic [3:0]  w_mask;
   logic [15:0] w_rm;
   logic        w_n;
   logic        w_z;
   logic        w_vf;
   logic [15:0] w_res;
   logic [3:0]  w_flags;
   logic [15:0] r_result;
   logic [3:0]  r_mask;
   logic [3:0]  r_flags;

   // Priority-resolve the strobes: the first one in port order wins.
   always_comb begin
      w_op = OP_NONE;
      if (add)       w_op = OP_ADD;
      else if (adc)  w_op = OP_ADC;
      else if (sub)  w_op = OP_SUB;
      else if (sbc)  w_op = OP_SBC;
      else if (inc2) w_op = OP_INC2;
      else if (dec2) w_op = OP_DEC2;
      else if (inc)  w_op = OP_INC;
      else if (dec)  w_op = OP_DEC;
      else if (clr)  w_op = OP_CLR;
      else if (com)  w_op = OP_COM;
      else if (neg)  w_op = OP_NEG;
      else if (tst)  w_op = OP_TST;
      else if (ror)  w_op = OP_ROR;
      else if (rol)  w_op = OP_ROL;
      else if (asr)  w_op = OP_ASR;
      else if (asl)  w_op = OP_ASL;
      else if (sxt)  w_op = OP_SXT;
      else if (mov)  w_op = OP_MOV;
      else if (cmp)  w_op = OP_CMP;
      else if (bit_) w_op = OP_BIT;
      else if (bic)  w_op = OP_BIC;
      else if (bis)  w_op = OP_BIS;
      else if (exor) w_op = OP_EXOR;
      else if (swab) w_op = OP_SWAB;
   end

`ifdef MYALU_BYTE_OPS_EN
   // Word-only ops ignore mbyte.
   assign w_byte = mbyte & ~(w_op inside {OP_NONE, OP_ADD, OP_SUB,
                                          OP_INC2, OP_DEC2, OP_SXT,
                                          OP_SWAB, OP_EXOR});
`else
   logic w_unused_mbyte;
   assign w_unused_mbyte = mbyte;
   assign w_byte = 1'b0;
`endif

   // Width-dependent constants; operands are zero-extended above the width.
   assign w_wmask  = w_byte ? 16'h00FF : 16'hFFFF;
   assign w_minneg = w_byte ? 16'h0080 : 16'h8000;
   assign w_maxpos = w_byte ? 16'h007F : 16'h7FFF;
   assign w_a      = in2 & w_wmask;
   assign w_b      = in1 & w_wmask;
   assign w_sa     = |(w_a & w_minneg);
   assign w_sb     = |(w_b & w_minneg);

   // With zero-extended operands bit 16 is the borrow in either width.
   assign w_sum   = {1'b0, w_b} + {1'b0, w_a};
   assign w_dif   = {1'b0, w_b} - {1'b0, w_a};
   assign w_cmpd  = {1'b0, w_a} - {1'b0, w_b};
   assign w_sum_s = |(w_sum[15:0] & w_minneg);
   assign w_dif_s = |(w_dif[15:0] & w_minneg);
   assign w_cmp_s = |(w_cmpd[15:0] & w_minneg);

   // Per-op raw result, carry, overflow and update mask.
   always_comb begin
      w_r    = 16'h0000;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_vnc  = 1'b0;
      w_mask = 4'b0000;
      unique case (w_op)
         OP_ADD: begin
            w_r    = w_sum[15:0];
            w_c    = w_sum[16];
            w_v    = (w_sa == w_sb) & (w_sum_s != w_sa);
            w_mask = 4'b1111;
         end
         OP_SUB: begin
            w_r    = w_dif[15:0];
            w_c    = w_dif[16];
            w_v    = (w_sa != w_sb) & (w_dif_s == w_sa);
            w_mask = 4'b1111;
         end
         OP_CMP: begin
            w_r    = w_cmpd[15:0];
            w_c    = w_cmpd[16];
            w_v    = (w_sa != w_sb) & (w_cmp_s == w_sb);
            w_mask = 4'b1111;
         end
         OP_ADC: begin
            w_r    = w_a + {15'h0000, ci};
            w_v    = ci & (w_a == w_maxpos);
            w_c    = ci & (w_a == w_wmask);
            w_mask = 4'b1111;
         end
         OP_SBC: begin
            w_r    = w_a - {15'h0000, ci};
            w_v    = (w_a == w_minneg);
            w_c    = ci & (w_a == 16'h0000);
            w_mask = 4'b1111;
         end
         OP_INC2: begin
            w_r = in2 + 16'd2;
         end
         OP_DEC2: begin
            w_r = in2 - 16'd2;
         end
         OP_INC: begin
            w_r    = w_a + 16'd1;
            w_v    = (w_a == w_maxpos);
            w_mask = 4'b1110;
         end
         OP_DEC: begin
            w_r    = w_a - 16'd1;
            w_v    = (w_a == w_minneg);
            w_mask = 4'b1110;
         end
         OP_CLR: begin
            w_mask = 4'b1111;
         end
         OP_COM: begin
            w_r    = ~w_a;
            w_c    = 1'b1;
            w_mask = 4'b1111;
         end
         OP_NEG: begin
            w_r    = 16'h0000 - w_a;
            w_v    = (w_a == w_minneg);
            w_c    = (w_a != 16'h0000);
            w_mask = 4'b1111;
         end
         OP_TST: begin
            w_r    = w_a;
            w_mask = 4'b1111;
         end
         OP_ROR: begin
            w_r    = (w_a >> 1) | (ci ? w_minneg : 16'h0000);
            w_c    = w_a[0];
            w_vnc  = 1'b1;
            w_mask = 4'b1111;
         end
         OP_ROL: begin
            w_r    = (w_a << 1) | {15'h0000, ci};
            w_c    = w_sa;
            w_vnc  = 1'b1;
            w_mask = 4'b1111;
         end
         OP_ASR: begin
            w_r    = (w_a >> 1) | (w_sa ? w_minneg : 16'h0000);
            w_c    = w_a[0];
            w_vnc  = 1'b1;
            w_mask = 4'b1111;
         end
         OP_ASL: begin
            w_r    = w_a << 1;
            w_c    = w_sa;
            w_vnc  = 1'b1;
            w_mask = 4'b1111;
         end
         OP_SXT: begin
            w_r    = {16{ni}};
            w_mask = 4'b0110;
         end
         OP_MOV: begin
            w_r    = w_a;
            w_mask = 4'b1110;
         end
         OP_BIT: begin
            w_r    = w_a & w_b;
            w_mask = 4'b1110;
         end
         OP_BIC: begin
            w_r    = w_b & ~w_a;
            w_mask = 4'b1110;
         end
         OP_BIS: begin
            w_r    = w_b | w_a;
            w_mask = 4'b1110;
         end
         OP_EXOR: begin
            w_r    = w_b ^ w_a;
            w_mask = 4'b1110;
         end
         OP_SWAB: begin
            w_r    = {in2[7:0], in2[15:8]};
            w_mask = 4'b1111;
         end
         default: begin
            w_r    = 16'h0000;
            w_mask = 4'b0000;
         end
      endcase
   end

   // Trim to the active width and derive N/Z, with swab/sxt exceptions.
   always_comb begin
      w_rm = w_r & w_wmask;
      w_n  = |(w_rm & w_minneg);
      w_z  = (w_rm == 16'h0000);
      if (w_op == OP_SWAB) begin
         w_n = w_rm[7];
         w_z = (w_rm[7:0] == 8'h00);
      end
      if (w_op == OP_SXT) begin
         w_z = ~ni;
      end
      w_vf    = w_vnc ? (w_n ^ w_c) : w_v;
      w_res   = w_byte ? {{8{w_rm[7]}}, w_rm[7:0]} : w_rm;
      w_flags = {w_n, w_z, w_vf, w_c} & w_mask;
   end

   // Output register: one-cycle latency, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= 16'h0000;
         r_mask   <= 4'b0000;
         r_flags  <= 4'b0000;
      end else begin
         r_result <= w_res;
         r_mask   <= w_mask;
         r_flags  <= w_flags;
      end
   end

   assign final_result = r_result;
   assign ccmask       = r_mask;
   assign final_flags  = r_flags;

endmodule

// File: tb/tb_my_alu.sv
// tb_my_alu: scoreboard bench for my_alu with an integer reference model.
// Directed test-plan vectors followed by randomized operations.
module tb_my_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        ni;
   logic        ci;
   logic        mbyte;
   logic [23:0] st;
   logic [15:0] final_result;
   logic [3:0]  ccmask;
   logic [3:0]  final_flags;

   always #5 clk = ~clk;

`ifdef MYALU_BYTE_OPS_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   localparam int ADD = 0, ADC = 1, SUB = 2, SBC = 3, INC2 = 4, DEC2 = 5;
   localparam int INC = 6, DEC = 7, CLR = 8, COM = 9, NEG = 10, TST = 11;
   localparam int ROR = 12, ROL = 13, ASR = 14, ASL = 15, SXT = 16;
   localparam int MOV = 17, CMP = 18, BIT = 19, BIC = 20, BIS = 21;
   localparam int EXOR = 22, SWAB = 23;

   typedef struct {
      logic [15:0] r;
      logic [3:0]  m;
      logic [3:0]  f;
      string       tag;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   my_alu dut (
      .clk(clk), .reset(reset), .in1(in1), .in2(in2),
      .ni(ni), .ci(ci), .mbyte(mbyte),
      .add(st[0]), .adc(st[1]), .sub(st[2]), .sbc(st[3]),
      .inc2(st[4]), .dec2(st[5]), .inc(st[6]), .dec(st[7]),
      .clr(st[8]), .com(st[9]), .neg(st[10]), .tst(st[11]),
      .ror(st[12]), .rol(st[13]), .asr(st[14]), .asl(st[15]),
      .sxt(st[16]), .mov(st[17]), .cmp(st[18]), .bit_(st[19]),
      .bic(st[20]), .bis(st[21]), .exor(st[22]), .swab(st[23]),
      .final_result(final_result), .ccmask(ccmask),
      .final_flags(final_flags)
   );

   function automatic exp_t mk(input string t, input logic [15:0] r,
                               input logic [3:0] m, input logic [3:0] f);
      exp_t e;
      e.tag = t; e.r = r; e.m = m; e.f = f;
      return e;
   endfunction

   function automatic bit ovf(input int x, input int h);
      return (x < -h) || (x >= h);
   endfunction

   // Reference model: plain integer arithmetic on the selected width.
   function automatic exp_t model(input logic [23:0] s, input logic [15:0] b16,
                                  input logic [15:0] a16, input logic nin,
                                  input logic cin, input logic mb);
      exp_t e;
      int op, w, sa, sb;
      int unsigned m, h, A, B, r;
      bit n, z, v, c;
      logic [3:0] mk4;
      e = mk("rand", 16'h0, 4'h0, 4'h0);
      op = -1;
      for (int i = 23; i >= 0; i--) if (s[i]) op = i;
      if (op < 0) return e;
      w = (BYTE_EN && mb && !(op inside {ADD, SUB, INC2, DEC2, SXT, SWAB, EXOR}))
          ? 8 : 16;
      m = (32'd1 << w) - 1;
      h = 32'd1 << (w - 1);
      A = 32'(a16) & m;
      B = 32'(b16) & m;
      sa = (A >= h) ? int'(A) - int'(m + 1) : int'(A);
      sb = (B >= h) ? int'(B) - int'(m + 1) : int'(B);
      r = 0; v = 0; c = 0;
      case (op)
         ADD:  begin r = (A + B) & m; c = (A + B) > m; v = ovf(sa + sb, int'(h)); end
         SUB:  begin r = (B + m + 1 - A) & m; c = B < A; v = ovf(sb - sa, int'(h)); end
         CMP:  begin r = (A + m + 1 - B) & m; c = A < B; v = ovf(sa - sb, int'(h)); end
         ADC:  begin r = (A + cin) & m; v = cin && A == h - 1; c = cin && A == m; end
         SBC:  begin r = (A + m + 1 - cin) & m; v = A == h; c = cin && A == 0; end
         INC2: r = (A + 2) & m;
         DEC2: r = (A + m - 1) & m;
         INC:  begin r = (A + 1) & m; v = r == h; end
         DEC:  begin r = (A + m) & m; v = A == h; end
         CLR:  r = 0;
         COM:  begin r = m - A; c = 1; end
         NEG:  begin r = (m + 1 - A) & m; v = r == h; c = r != 0; end
         TST:  r = A;
         ROR:  begin r = (A >> 1) + (cin ? h : 0); c = A[0]; end
         ROL:  begin r = ((A * 2) + cin) & m; c = A >= h; end
         ASR:  begin r = (A >> 1) + ((A >= h) ? h : 0); c = A[0]; end
         ASL:  begin r = (A * 2) & m; c = A >= h; end
         SXT:  r = nin ? 32'hFFFF : 0;
         MOV:  r = A;
         BIT:  r = A & B;
         BIC:  r = B & ~A & m;
         BIS:  r = B | A;
         EXOR: r = B ^ A;
         SWAB: r = ((A & 255) << 8) | (A >> 8);
         default: r = 0;
      endcase
      n = r >= h;
      z = r == 0;
      if (op == SXT) z = !nin;
      if (op == SWAB) begin n = r[7]; z = (r & 255) == 0; end
      if (op inside {ROR, ROL, ASR, ASL}) v = n ^ c;
      if (op inside {INC2, DEC2}) mk4 = 4'b0000;
      else if (op == SXT) mk4 = 4'b0110;
      else if (op inside {INC, DEC, MOV, BIT, BIC, BIS, EXOR}) mk4 = 4'b1110;
      else mk4 = 4'b1111;
      e.r = (w == 8 && r >= 128) ? 16'(r | 32'hFF00) : 16'(r);
      e.m = mk4;
      e.f = {n, z, v, c} & mk4;
      return e;
   endfunction

   task automatic issue(input logic rst, input logic [23:0] s,
                        input logic [15:0] b, input logic [15:0] a,
                        input logic nin, input logic cin, input logic mb,
                        input exp_t e);
      reset = rst; st = s; in1 = b; in2 = a;
      ni = nin; ci = cin; mbyte = mb;
      q.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [23:0] one(input int i);
      return 24'd1 << i;
   endfunction

   function automatic logic [15:0] pick();
      logic [15:0] tbl [8] = '{16'h0000, 16'h0001, 16'h007F, 16'h0080,
                               16'h00FF, 16'h7FFF, 16'h8000, 16'hFFFF};
      if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 7)];
      return 16'($urandom);
   endfunction

   // Monitor: pop one expectation per registered output update.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (final_result !== e.r || ccmask !== e.m || final_flags !== e.f) begin
               n_bad++;
               $display("FAIL %s: got r=%h m=%b f=%b, expected r=%h m=%b f=%b",
                        e.tag, final_result, ccmask, final_flags, e.r, e.m, e.f);
            end
         end
      end
   end

   // Driver: directed vectors, then randomized traffic.
   initial begin
      logic [23:0] s;
      logic [15:0] a, b;
      logic nin, cin, mb, rst;
      issue(1, one(ADD), 16'd5, 16'd7, 0, 0, 0, mk("reset0", 16'h0, 4'h0, 4'h0));
      issue(1, one(ADD), 16'd5, 16'd7, 0, 0, 0, mk("reset1", 16'h0, 4'h0, 4'h0));
      issue(0, one(ADD), 16'd5, 16'd7, 0, 0, 0, mk("add_5_7", 16'd12, 4'hF, 4'b0000));
      issue(0, one(ADD), 16'h7FFF, 16'h0001, 0, 0, 0,
            mk("add_ovf", 16'h8000, 4'hF, 4'b1010));
      issue(0, one(SUB), 16'h0000, 16'h0001, 0, 0, 0,
            mk("sub_borrow", 16'hFFFF, 4'hF, 4'b1001));
      issue(0, one(CMP), 16'd3, 16'd3, 0, 0, 0, mk("cmp_eq", 16'h0, 4'hF, 4'b0100));
      issue(0, one(INC), 16'h0, 16'h7FFF, 0, 0, 0,
            mk("inc_ovf", 16'h8000, 4'hE, 4'b1010));
      issue(0, one(NEG), 16'h0, 16'h0080, 0, 0, 1,
            BYTE_EN ? mk("negb", 16'hFF80, 4'hF, 4'b1011)
                    : mk("negb", 16'hFF80, 4'hF, 4'b1001));
      issue(0, one(ROR), 16'h0, 16'h0001, 0, 0, 0, mk("ror_1", 16'h0, 4'hF, 4'b0111));
      issue(0, one(SXT), 16'h0, 16'h0, 1, 0, 0, mk("sxt_n", 16'hFFFF, 4'h6, 4'b0000));
      issue(0, one(SWAB), 16'h0, 16'h1280, 0, 0, 0,
            mk("swab", 16'h8012, 4'hF, 4'b0000));
      issue(0, one(DEC2), 16'h0, 16'h0400, 0, 0, 0,
            mk("dec2", 16'h03FE, 4'h0, 4'b0000));
      issue(0, one(ADD) | one(SUB), 16'd5, 16'd7, 0, 0, 0,
            mk("add_sub_prio", 16'd12, 4'hF, 4'b0000));
      issue(0, 24'h0, 16'h1234, 16'h5678, 1, 1, 0, mk("no_op", 16'h0, 4'h0, 4'h0));
      issue(0, one(ADD), 16'h00FF, 16'h0001, 0, 0, 1,
            mk("addb_word", 16'h0100, 4'hF, 4'b0000));
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0:       s = 24'h0;
            1:       s = 24'($urandom);
            default: s = one($urandom_range(0, 23));
         endcase
         b = pick();
         a = pick();
         nin = 1'($urandom);
         cin = 1'($urandom);
         mb = 1'($urandom);
         rst = ($urandom_range(0, 49) == 0);
         issue(rst, s, b, a, nin, cin, mb,
               rst ? mk("rand_reset", 16'h0, 4'h0, 4'h0)
                   : model(s, b, a, nin, cin, mb));
      end
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
